// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings for the memory responder (sizes, FSM states).
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_ctrl.sv
// ============================================================================
// Module   : mem_lane_ctrl
// Purpose  : Little-endian byte-lane steering: byte enables, store merge and
//            right-aligned zero-extended load extraction.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lane_ctrl
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ram_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] wrep;
  logic [31:0] rshift;

  always_comb begin
    byte_en_o = 4'b0000;
    wrep      = wdata_i;
    rdata_o   = 32'h0;
    rshift    = ram_word_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SIZE_WORD: begin
        byte_en_o = 4'b1111;
        rdata_o   = ram_word_i;
      end
      SIZE_HALF: begin
        byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wrep      = {2{wdata_i[15:0]}};
        rdata_o   = {16'h0, (addr_lo_i[1] ? ram_word_i[31:16] : ram_word_i[15:0])};
      end
      SIZE_BYTE: begin
        byte_en_o = 4'b0001 << addr_lo_i;
        wrep      = {4{wdata_i[7:0]}};
        rdata_o   = {24'h0, rshift[7:0]};
      end
      default: begin
        byte_en_o = 4'b0000;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wword_o[8*gi +: 8] = byte_en_o[gi] ? wrep[8*gi +: 8] : ram_word_i[8*gi +: 8];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Fixed-latency RAM responder with MemReady handshake for the
//            multicycle CPU. Optional macro MEM_ALIGN_CHECK_EN flags misaligned
//            half/word accesses as errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemError,
  output logic        Busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [1:0]        size_q;
  logic              write_q, err_q;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              w_req, w_idle, w_accept, w_to_resp, w_commit;
  logic              w_in_err, w_in_misalign;
  logic [31:0]       w_addr, w_wdata;
  logic [1:0]        w_size;
  logic              w_write, w_err;
  logic [AW-1:0]     w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_merged, w_lane_rdata;

  assign w_req    = MemRead | MemWrite;
  assign w_idle   = (state_q == ST_IDLE);
  assign w_accept = w_idle & w_req;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_in_misalign = misaligned(Size, Address[1:0]);
`else
  assign w_in_misalign = 1'b0;
`endif

  assign w_in_err = (MemRead & MemWrite) | (Size == SIZE_RSVD) |
                    (|Address[31:AW+2]) | w_in_misalign;

  // With LATENCY=1 the commit edge is the acceptance edge, so live inputs are used.
  assign w_addr  = w_idle ? Address   : addr_q;
  assign w_wdata = w_idle ? WriteData : wdata_q;
  assign w_size  = w_idle ? Size      : size_q;
  assign w_write = w_idle ? MemWrite  : write_q;
  assign w_err   = w_idle ? w_in_err  : err_q;
  assign w_idx   = w_addr[AW+1:2];

  mem_lane_ctrl u_lane (
    .size_i     (w_size),
    .addr_lo_i  (w_addr[1:0]),
    .wdata_i    (w_wdata),
    .ram_word_i (mem_q[w_idx]),
    .byte_en_o  (w_be),
    .wword_o    (w_merged),
    .rdata_o    (w_lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_to_resp = (state_d == ST_RESP);
  assign w_commit  = w_to_resp & w_write & ~w_err & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SIZE_WORD;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        addr_q  <= Address;
        wdata_q <= WriteData;
        size_q  <= Size;
        write_q <= MemWrite;
        err_q   <= w_in_err;
      end
      if (w_to_resp) begin
        if (w_err) begin
          rdata_q <= '0;
        end else if (!w_write) begin
          rdata_q <= w_lane_rdata;
        end
      end
    end
  end

  // RAM contents survive reset; only the request is aborted.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) mem_q[w_idx][8*i +: 8] <= w_merged[8*i +: 8];
      end
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = (state_q == ST_RESP);
  assign MemError = MemReady & err_q;
  assign Busy     = ~reset & (~w_idle | w_req);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Scoreboard bench for mem_responder (LATENCY=2 and LATENCY=1 DUTs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, wdata, addr1, wdata1;
  logic [1:0]  size, size1;
  logic [31:0] rdata, rdata1;
  logic        ready, merr, busy, ready1, merr1, busy1;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .MemRead(rd), .MemWrite(wr), .Address(addr),
    .WriteData(wdata), .Size(size), .ReadData(rdata), .MemReady(ready),
    .MemError(merr), .Busy(busy)
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .Address(addr1),
    .WriteData(wdata1), .Size(size1), .ReadData(rdata1), .MemReady(ready1),
    .MemError(merr1), .Busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL L2 unexpected response: got MemReady=1 expected none");
      end else begin
        e0 = q.pop_front();
        chk("L2 ReadData", rdata, e0.data);
        chk("L2 MemError", 32'(merr), 32'(e0.err));
      end
    end
  end

  always @(negedge clk) begin
    if (ready1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL L1 unexpected response: got MemReady=1 expected none");
      end else begin
        e1 = q1.pop_front();
        chk("L1 ReadData", rdata1, e1.data);
        chk("L1 MemError", 32'(merr1), 32'(e1.err));
      end
    end
  end

  // One request on the LATENCY=2 DUT; Busy spans request cycle, WAIT and RESP.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s,
                       input logic [31:0] ed, input logic ee, input string name);
    int busy_cnt;
    bit done;
    busy_cnt = 0;
    done     = 1'b0;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; size = s;
    q.push_back(exp_t'{data: ed, err: ee});
    #1;
    if (busy) busy_cnt++;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: got Busy stuck high expected release", name);
    end
    chk({name, " Busy cycles"}, 32'(busy_cnt), 32'd3);
  endtask

  logic [7:0] pat;
  int         cnt;

  initial begin
    reset = 1'b1;
    rd = 0; wr = 0; addr = 0; wdata = 0; size = SIZE_WORD;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0; size1 = SIZE_WORD;
    repeat (2) @(negedge clk);
    chk("reset ReadData", rdata, 32'h0);
    chk("reset MemReady", 32'(ready), 32'd0);
    chk("reset MemError", 32'(merr), 32'd0);
    chk("reset Busy", 32'(busy), 32'd0);
    reset = 1'b0;

    issue(0, 1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 32'h0,        0, "wr word 0x10");
    issue(1, 0, 32'h10, 32'h0,        SIZE_WORD, 32'hDEADBEEF, 0, "rd word 0x10");
    issue(0, 1, 32'h00, 32'h600DF00D, SIZE_WORD, 32'hDEADBEEF, 0, "wr word 0x00");
    issue(0, 1, 32'h20, 32'h11223344, SIZE_WORD, 32'hDEADBEEF, 0, "wr word 0x20");
    issue(0, 1, 32'h22, 32'h000000AA, SIZE_BYTE, 32'hDEADBEEF, 0, "wr byte 0x22");
    issue(1, 0, 32'h20, 32'h0,        SIZE_WORD, 32'h11AA3344, 0, "rd word 0x20");
    issue(1, 0, 32'h22, 32'h0,        SIZE_HALF, 32'h000011AA, 0, "rd half 0x22");
    issue(1, 0, 32'h23, 32'h0,        SIZE_BYTE, 32'h00000011, 0, "rd byte 0x23");
    issue(0, 1, 32'h12, 32'h00001234, SIZE_HALF, 32'h00000011, 0, "wr half 0x12");
    issue(1, 0, 32'h10, 32'h0,        SIZE_WORD, 32'h1234BEEF, 0, "rd word 0x10 b");
    issue(1, 1, 32'h20, 32'h0,        SIZE_WORD, 32'h0,        1, "err rd+wr");
    issue(0, 1, 32'h20, 32'hFFFFFFFF, SIZE_RSVD, 32'h0,        1, "err size11");
    issue(0, 1, 32'h400, 32'h55555555, SIZE_WORD, 32'h0,       1, "err range wr");
    issue(1, 0, 32'h20, 32'h0,        SIZE_WORD, 32'h11AA3344, 0, "rd 0x20 intact");
    issue(1, 0, 32'h00, 32'h0,        SIZE_WORD, 32'h600DF00D, 0, "rd 0x00 intact");
    issue(0, 1, 32'h30, 32'hCAFEF00D, SIZE_WORD, 32'h600DF00D, 0, "wr word 0x30");
    issue(1, 0, 32'h21, 32'h0,        SIZE_BYTE, 32'h00000033, 0, "rd byte 0x21");
`ifdef MEM_ALIGN_CHECK_EN
    issue(1, 0, 32'h21, 32'h0,        SIZE_HALF, 32'h0,        1, "rd half 0x21");
    issue(1, 0, 32'h13, 32'h0,        SIZE_WORD, 32'h0,        1, "rd word 0x13");
`else
    issue(1, 0, 32'h21, 32'h0,        SIZE_HALF, 32'h00003344, 0, "rd half 0x21");
    issue(1, 0, 32'h13, 32'h0,        SIZE_WORD, 32'h1234BEEF, 0, "rd word 0x13");
`endif
    issue(1, 0, 32'h10, 32'h0,        SIZE_WORD, 32'h1234BEEF, 0, "rd word 0x10 c");

    // Abort a write in WAIT with an asynchronous reset between clock edges.
    @(negedge clk);
    wr = 1'b1; addr = 32'h30; wdata = 32'h12345678; size = SIZE_WORD;
    @(posedge clk);
    #1;
    wr = 1'b0;
    chk("WAIT Busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset ReadData", rdata, 32'h0);
    chk("async reset MemReady", 32'(ready), 32'd0);
    chk("async reset MemError", 32'(merr), 32'd0);
    chk("async reset Busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    issue(1, 0, 32'h30, 32'h0,  SIZE_WORD, 32'hCAFEF00D, 0, "rd 0x30 after abort");
    issue(1, 0, 32'h404, 32'h0, SIZE_WORD, 32'h0,        1, "err range rd");

    // LATENCY=1: single write, then continuous reads, then one dropped-in-RESP read.
    @(negedge clk);
    wr1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h0BADCAFE; size1 = SIZE_WORD;
    q1.push_back(exp_t'{data: 32'h0, err: 1'b0});
    @(negedge clk);
    chk("L1 write MemReady", 32'(ready1), 32'd1);
    wr1 = 1'b0;
    @(negedge clk);
    chk("L1 idle MemReady", 32'(ready1), 32'd0);
    rd1 = 1'b1;
    repeat (4) q1.push_back(exp_t'{data: 32'h0BADCAFE, err: 1'b0});
    pat = 8'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = ready1;
    end
    rd1 = 1'b0;
    chk("L1 back-to-back pattern", 32'(pat), 32'h55);

    @(negedge clk);
    rd1 = 1'b1;
    q1.push_back(exp_t'{data: 32'h0BADCAFE, err: 1'b0});
    cnt = 0;
    @(negedge clk);
    if (ready1) cnt++;
    rd1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready1) cnt++;
    end
    chk("L1 single response count", 32'(cnt), 32'd1);

    repeat (3) @(negedge clk);
    chk("L2 scoreboard drained", 32'(q.size()), 32'd0);
    chk("L1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
